egress_voq: RTL and testbench

//  Per-egress-port virtual output queue: a FIFO of packet start pointers.

---
 rtl/egress_voq.sv | 171 +++++++++++++++++
 tb/tb_egress_voq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/egress_voq.sv
// Per-egress-port virtual output queue: FIFO of packet start pointers with
// first-word-fall-through head, overflow drop reporting and synchronous flush.

module egress_voq_chk #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input logic             clk,
    input logic             rst_n,
    input logic [CNT_W-1:0] count,
    input logic             full,
    input logic             empty,
    input logic             head_valid
);

    count_le_depth_a: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CNT_W'(DEPTH));
    full_empty_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(full && empty));
    full_flag_a: assert property (@(posedge clk) disable iff (!rst_n)
        full == (count == CNT_W'(DEPTH)));
    empty_flag_a: assert property (@(posedge clk) disable iff (!rst_n)
        empty == (count == CNT_W'(0)));
    head_valid_a: assert property (@(posedge clk) disable iff (!rst_n)
        head_valid == !empty);

endmodule

module egress_voq #(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 16,
    parameter int DROP_CNT_W = 16
) (
    input  logic                       switch_clk,
    input  logic                       switch_rst_n,
    input  logic                       wr_req_i,
    input  logic [ADDR_W-1:0]          wr_ptr_i,
    input  logic                       flush_i,
    output logic                       head_valid_o,
    output logic [ADDR_W-1:0]          head_ptr_o,
    input  logic                       head_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       drop_o,
    output logic [ADDR_W-1:0]          drop_ptr_o,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + DROP_CNT_W'(1);
        end
    endfunction

    logic [ADDR_W-1:0]     mem_r [DEPTH];
    logic [IDX_W-1:0]      rd_idx_r, wr_idx_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_r, empty_r;
    logic [ADDR_W-1:0]     head_ptr_r;
    logic                  drop_r;
    logic [ADDR_W-1:0]     drop_ptr_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    logic                  pop_s, push_s, push_eff_s, pop_eff_s, drop_s;
    logic [IDX_W-1:0]      rd_idx_nxt_s, wr_idx_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [ADDR_W-1:0]     head_nxt_s;

    // Handshake decode and next-state; head is precomputed so head_ptr_o is a flop.
    always_comb begin
        pop_s        = ~empty_r & head_ready_i;
        push_s       = wr_req_i & (~full_r | pop_s);
        push_eff_s   = push_s & ~flush_i;
        pop_eff_s    = pop_s & ~flush_i;
        drop_s       = wr_req_i & full_r & ~pop_s & ~flush_i;
        rd_idx_nxt_s = rd_idx_r;
        wr_idx_nxt_s = wr_idx_r;
        count_nxt_s  = count_r;
        head_nxt_s   = head_ptr_r;

        if (flush_i) begin
            rd_idx_nxt_s = IDX_W'(0);
            wr_idx_nxt_s = IDX_W'(0);
        end else begin
            if (pop_eff_s) begin
                rd_idx_nxt_s = rd_idx_r + IDX_W'(1);
            end else begin
                rd_idx_nxt_s = rd_idx_r;
            end
            if (push_eff_s) begin
                wr_idx_nxt_s = wr_idx_r + IDX_W'(1);
            end else begin
                wr_idx_nxt_s = wr_idx_r;
            end
        end

        case ({flush_i, push_eff_s, pop_eff_s})
            3'b010:  count_nxt_s = count_r + CNT_W'(1);
            3'b001:  count_nxt_s = count_r - CNT_W'(1);
            3'b011:  count_nxt_s = count_r;
            3'b000:  count_nxt_s = count_r;
            default: count_nxt_s = CNT_W'(0);
        endcase

        // The slot being written is the next head only when it is the sole entry.
        if (push_eff_s && (wr_idx_r == rd_idx_nxt_s)) begin
            head_nxt_s = wr_ptr_i;
        end else begin
            head_nxt_s = mem_r[rd_idx_nxt_s];
        end
    end

    // Queue control, head and drop reporting registers.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            rd_idx_r   <= IDX_W'(0);
            wr_idx_r   <= IDX_W'(0);
            count_r    <= CNT_W'(0);
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            head_ptr_r <= ADDR_W'(0);
            drop_r     <= 1'b0;
            drop_ptr_r <= ADDR_W'(0);
            drop_cnt_r <= DROP_CNT_W'(0);
        end else begin
            rd_idx_r   <= rd_idx_nxt_s;
            wr_idx_r   <= wr_idx_nxt_s;
            count_r    <= count_nxt_s;
            full_r     <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r    <= (count_nxt_s == CNT_W'(0));
            head_ptr_r <= head_nxt_s;
            drop_r     <= drop_s;
            if (drop_s) begin
                drop_ptr_r <= wr_ptr_i;
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    // Pointer storage; deliberately not reset.
    always_ff @(posedge switch_clk) begin
        if (push_eff_s) begin
            mem_r[wr_idx_r] <= wr_ptr_i;
        end
    end

    assign head_valid_o = ~empty_r;
    assign head_ptr_o   = head_ptr_r;
    assign count_o      = count_r;
    assign full_o       = full_r;
    assign empty_o      = empty_r;
    assign drop_o       = drop_r;
    assign drop_ptr_o   = drop_ptr_r;
    assign drop_cnt_o   = drop_cnt_r;

    egress_voq_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk        (switch_clk),
        .rst_n      (switch_rst_n),
        .count      (count_r),
        .full       (full_r),
        .empty      (empty_r),
        .head_valid (head_valid_o)
    );

endmodule

// File: tb/tb_egress_voq.sv
// Directed plus randomized bench for egress_voq against a queue-based reference model;
// a second narrow-counter instance exercises drop counter saturation.

module tb_egress_voq;

    localparam int DEPTH = 16;

    logic        clk_s = 1'b0;
    logic        rst_n_s;
    logic        wr_req_s, flush_s, head_ready_s;
    logic [7:0]  wr_ptr_s;
    logic        head_valid_s, full_s, empty_s, drop_s;
    logic [7:0]  head_ptr_s, drop_ptr_s;
    logic [4:0]  count_s;
    logic [15:0] drop_cnt_s;

    logic        wr_req2_s, flush2_s, head_ready2_s;
    logic [7:0]  wr_ptr2_s;
    logic        head_valid2_s, full2_s, empty2_s, drop2_s;
    logic [7:0]  head_ptr2_s, drop_ptr2_s;
    logic [1:0]  count2_s;
    logic [3:0]  drop_cnt2_s;

    int          compared = 0;
    int          mismatched = 0;

    logic [7:0]  q_m [$];
    logic        exp_drop_m;
    logic [7:0]  exp_drop_ptr_m;
    int          exp_dcnt_m;

    always #5 clk_s = ~clk_s;

    egress_voq #(.ADDR_W(8), .DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
        .switch_clk   (clk_s),
        .switch_rst_n (rst_n_s),
        .wr_req_i     (wr_req_s),
        .wr_ptr_i     (wr_ptr_s),
        .flush_i      (flush_s),
        .head_valid_o (head_valid_s),
        .head_ptr_o   (head_ptr_s),
        .head_ready_i (head_ready_s),
        .count_o      (count_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .drop_o       (drop_s),
        .drop_ptr_o   (drop_ptr_s),
        .drop_cnt_o   (drop_cnt_s)
    );

    egress_voq #(.ADDR_W(8), .DEPTH(2), .DROP_CNT_W(4)) dut_sat (
        .switch_clk   (clk_s),
        .switch_rst_n (rst_n_s),
        .wr_req_i     (wr_req2_s),
        .wr_ptr_i     (wr_ptr2_s),
        .flush_i      (flush2_s),
        .head_valid_o (head_valid2_s),
        .head_ptr_o   (head_ptr2_s),
        .head_ready_i (head_ready2_s),
        .count_o      (count2_s),
        .full_o       (full2_s),
        .empty_o      (empty2_s),
        .drop_o       (drop2_s),
        .drop_ptr_o   (drop_ptr2_s),
        .drop_cnt_o   (drop_cnt2_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count_s), 32'(q_m.size()));
        chk("empty", 32'(empty_s), 32'(q_m.size() == 0));
        chk("full", 32'(full_s), 32'(q_m.size() == DEPTH));
        chk("head_valid", 32'(head_valid_s), 32'(q_m.size() != 0));
        if (q_m.size() != 0) chk("head_ptr", 32'(head_ptr_s), 32'(q_m[0]));
        chk("drop", 32'(drop_s), 32'(exp_drop_m));
        chk("drop_ptr", 32'(drop_ptr_s), 32'(exp_drop_ptr_m));
        chk("drop_cnt", 32'(drop_cnt_s), 32'(exp_dcnt_m));
    endtask

    task automatic check_reset_outputs();
        chk("rst_count", 32'(count_s), 32'd0);
        chk("rst_empty", 32'(empty_s), 32'd1);
        chk("rst_full", 32'(full_s), 32'd0);
        chk("rst_head_valid", 32'(head_valid_s), 32'd0);
        chk("rst_drop", 32'(drop_s), 32'd0);
        chk("rst_drop_ptr", 32'(drop_ptr_s), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt_s), 32'd0);
        chk("rst_sat_drop_cnt", 32'(drop_cnt2_s), 32'd0);
    endtask

    task automatic model_reset();
        q_m.delete();
        exp_drop_m     = 1'b0;
        exp_drop_ptr_m = 8'h00;
        exp_dcnt_m     = 0;
    endtask

    // One clock of the main instance: drive, update the reference model, compare.
    task automatic step(input logic req, input logic [7:0] ptr, input logic rdy, input logic fl);
        bit pop, push, ovf;
        wr_req_s     = req;
        wr_ptr_s     = ptr;
        head_ready_s = rdy;
        flush_s      = fl;
        pop  = (q_m.size() != 0) && rdy;
        push = req && ((q_m.size() < DEPTH) || pop);
        ovf  = req && !push;
        @(posedge clk_s);
        #1;
        if (fl) begin
            q_m.delete();
            exp_drop_m = 1'b0;
        end else begin
            if (pop) void'(q_m.pop_front());
            if (push) q_m.push_back(ptr);
            exp_drop_m = ovf;
            if (ovf) begin
                exp_drop_ptr_m = ptr;
                if (exp_dcnt_m < 65535) exp_dcnt_m++;
            end
        end
        check_all();
    endtask

    initial begin
        int p_req, p_rdy, fill2, dcnt2;
        rst_n_s = 1'b0;
        wr_req_s = 1'b0; wr_ptr_s = 8'h00; flush_s = 1'b0; head_ready_s = 1'b0;
        wr_req2_s = 1'b0; wr_ptr2_s = 8'h00; flush2_s = 1'b0; head_ready2_s = 1'b0;
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk_s);
        rst_n_s = 1'b1;

        // 1-2: three pushes without ready, then drain
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("t1_head_first", 32'(head_ptr_s), 32'h11);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        chk("t1_count3", 32'(count_s), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_empty", 32'(empty_s), 32'd1);

        // 3: fill then overflow
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        chk("t3_drop_ptr", 32'(drop_ptr_s), 32'hAB);
        chk("t3_drop_cnt", 32'(drop_cnt_s), 32'd1);

        // 4: push with pop while full, then drain checking order
        step(1'b1, 8'hCD, 1'b1, 1'b0);
        chk("t4_no_drop", 32'(drop_s), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // count==1 push & pop: head moves to new entry
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("one_pushpop_head", 32'(head_ptr_s), 32'hA5);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // 5: flush beats a simultaneous write
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("t5_flush_count", 32'(count_s), 32'd0);

        // 6: narrow counter saturation on the DEPTH=2 instance
        step(1'b0, 8'h00, 1'b0, 1'b0);
        fill2 = 0;
        dcnt2 = 0;
        for (int i = 0; i < 2 + 19; i++) begin
            wr_req2_s = 1'b1;
            wr_ptr2_s = 8'(i);
            @(posedge clk_s);
            #1;
            if (fill2 < 2) fill2++;
            else if (dcnt2 < 15) dcnt2++;
            chk("t6_sat_cnt", 32'(drop_cnt2_s), 32'(dcnt2));
            chk("t6_sat_count", 32'(count2_s), 32'(fill2));
        end
        wr_req2_s = 1'b0;
        chk("t6_saturated", 32'(drop_cnt2_s), 32'hF);

        // 7: random traffic in phases of differing bias
        for (int ph = 0; ph < 10; ph++) begin
            p_req = (ph % 3 == 0) ? 90 : ((ph % 3 == 1) ? 50 : 20);
            p_rdy = (ph % 2 == 0) ? 25 : 70;
            for (int i = 0; i < 1000; i++) begin
                step($urandom_range(0, 99) < p_req, 8'($urandom),
                     $urandom_range(0, 99) < p_rdy, $urandom_range(0, 255) == 0);
            end
        end

        // 8: asynchronous reset mid-traffic
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        #3;
        rst_n_s = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        wr_req_s = 1'b1;
        @(posedge clk_s);
        #1;
        check_reset_outputs();
        @(negedge clk_s);
        rst_n_s = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
